// File: rtl/train_scheduler.sv
// train_scheduler: sequences TRAIN/TEST phases over epochs, issues sample tokens, tracks in-flight samples.
// Optional macro SCHED_LR_DECAY_EN enables step-decay of the learning rate every DECAY_EPOCHS epochs.
`default_nettype none

module train_scheduler #(
    parameter int             WV           = 4,
    parameter int             CW           = 16,
    parameter int             MAX_INFLIGHT = 4,
    parameter logic [WV-1:0]  LR_INIT      = 4'b0100,
    parameter logic [WV-1:0]  LR_MIN       = 4'b0001,
    parameter int             DECAY_EPOCHS = 2
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          iStart,
    input  logic [CW-1:0] iNumTrain,
    input  logic [CW-1:0] iNumTest,
    input  logic [CW-1:0] iNumEpoch,
    output logic          oMode,
    output logic [WV-1:0] oLR,
    output logic          oValid_Sample,
    input  logic          iReady_Sample,
    output logic [CW-1:0] oData_Sample,
    input  logic          iValid_Done,
    output logic          oReady_Done,
    output logic [CW-1:0] oEpoch,
    output logic          oBusy,
    output logic          oDone
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_TRAIN   = 3'd1,
        S_DRAIN_T = 3'd2,
        S_TEST    = 3'd3,
        S_DRAIN_E = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam logic          MODE_TRAIN     = 1'b1;
    localparam logic          MODE_TEST      = 1'b0;
    localparam logic [CW-1:0] C_MAX_INFLIGHT = CW'(MAX_INFLIGHT);

    state_t        state_q;
    logic          mode_q;
    logic [WV-1:0] lr_q;
    logic [CW-1:0] issued_q;
    logic [CW-1:0] inflight_q;
    logic [CW-1:0] epoch_q;
    logic          done_q;
    logic [CW-1:0] num_train_q;
    logic [CW-1:0] num_test_q;
    logic [CW-1:0] num_epoch_q;

    logic          w_phase;
    logic [CW-1:0] w_limit;
    logic          w_valid;
    logic          w_issue;
    logic          w_complete;
    logic [CW-1:0] w_epoch_d;
    logic [WV-1:0] w_lr_d;

    always_comb begin
        w_phase    = (state_q == S_TRAIN) || (state_q == S_TEST);
        w_limit    = (state_q == S_TRAIN) ? num_train_q : num_test_q;
        w_valid    = w_phase && (issued_q < w_limit) && (inflight_q < C_MAX_INFLIGHT);
        w_issue    = w_valid && iReady_Sample;
        w_complete = iValid_Done && (inflight_q != '0);
        w_epoch_d  = epoch_q + CW'(1);
    end

`ifdef SCHED_LR_DECAY_EN
    logic [CW-1:0] decay_q;
    logic [CW-1:0] w_decay_d;
    logic          w_decay_wrap;
    logic [WV-1:0] w_lr_half;

    always_comb begin
        w_decay_d    = decay_q + CW'(1);
        w_decay_wrap = (w_decay_d == CW'(DECAY_EPOCHS));
        w_lr_half    = lr_q >> 1;
        w_lr_d       = lr_q;
        if (w_decay_wrap) begin
            w_lr_d = (w_lr_half < LR_MIN) ? LR_MIN : w_lr_half;
        end
    end

    // Decay counter restarts on every accepted start so each run sees the same schedule.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            decay_q <= '0;
        end else if ((state_q == S_IDLE || state_q == S_DONE) && iStart) begin
            decay_q <= '0;
        end else if (state_q == S_DRAIN_E && inflight_q == '0) begin
            decay_q <= w_decay_wrap ? '0 : w_decay_d;
        end
    end
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^{LR_MIN, DECAY_EPOCHS};
    assign w_lr_d       = LR_INIT;
`endif

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q     <= S_IDLE;
            mode_q      <= MODE_TEST;
            lr_q        <= LR_INIT;
            issued_q    <= '0;
            inflight_q  <= '0;
            epoch_q     <= '0;
            done_q      <= 1'b0;
            num_train_q <= '0;
            num_test_q  <= '0;
            num_epoch_q <= '0;
        end else begin
            if (w_issue && !w_complete) begin
                inflight_q <= inflight_q + CW'(1);
            end else if (!w_issue && w_complete) begin
                inflight_q <= inflight_q - CW'(1);
            end
            if (w_issue) begin
                issued_q <= issued_q + CW'(1);
            end

            case (state_q)
                S_IDLE, S_DONE: begin
                    if (iStart) begin
                        num_train_q <= iNumTrain;
                        num_test_q  <= iNumTest;
                        num_epoch_q <= iNumEpoch;
                        epoch_q     <= '0;
                        lr_q        <= LR_INIT;
                        issued_q    <= '0;
                        if (iNumEpoch == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            mode_q  <= MODE_TEST;
                        end else begin
                            state_q <= S_TRAIN;
                            done_q  <= 1'b0;
                            mode_q  <= MODE_TRAIN;
                        end
                    end
                end
                S_TRAIN: begin
                    if (issued_q == num_train_q) begin
                        state_q <= S_DRAIN_T;
                    end
                end
                // Mode only flips once the pipeline is empty, so no update lands under the wrong mode.
                S_DRAIN_T: begin
                    if (inflight_q == '0) begin
                        issued_q <= '0;
                        state_q  <= S_TEST;
                        mode_q   <= MODE_TEST;
                    end
                end
                S_TEST: begin
                    if (issued_q == num_test_q) begin
                        state_q <= S_DRAIN_E;
                    end
                end
                S_DRAIN_E: begin
                    if (inflight_q == '0) begin
                        issued_q <= '0;
                        epoch_q  <= w_epoch_d;
                        lr_q     <= w_lr_d;
                        if (w_epoch_d == num_epoch_q) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_TRAIN;
                            mode_q  <= MODE_TRAIN;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign oMode         = mode_q;
    assign oLR           = lr_q;
    assign oValid_Sample = w_valid;
    assign oData_Sample  = issued_q;
    assign oReady_Done   = (inflight_q != '0);
    assign oEpoch        = epoch_q;
    assign oBusy         = (state_q != S_IDLE) && (state_q != S_DONE);
    assign oDone         = done_q;

endmodule

`default_nettype wire

// File: tb/tb_train_scheduler.sv
// tb_train_scheduler: randomized bench for train_scheduler against a token-sequence reference model.
// Honors SCHED_LR_DECAY_EN to pick the expected learning-rate schedule.
`default_nettype none

module tb_train_scheduler;

    localparam int WV     = 4;
    localparam int CW     = 16;
    localparam int MAXI   = 4;
    localparam int LRI    = 4;
    localparam int LRM    = 1;
    localparam int DECAY  = 2;
    localparam int M_TRAIN = 1;
    localparam int M_TEST  = 0;

    logic          iCLK = 1'b0;
    logic          iRST = 1'b1;
    logic          iStart = 1'b0;
    logic [CW-1:0] iNumTrain = '0;
    logic [CW-1:0] iNumTest = '0;
    logic [CW-1:0] iNumEpoch = '0;
    logic          iReady_Sample = 1'b0;
    logic          iValid_Done = 1'b0;
    logic          oMode;
    logic [WV-1:0] oLR;
    logic          oValid_Sample;
    logic [CW-1:0] oData_Sample;
    logic          oReady_Done;
    logic [CW-1:0] oEpoch;
    logic          oBusy;
    logic          oDone;

    train_scheduler #(
        .WV(WV), .CW(CW), .MAX_INFLIGHT(MAXI),
        .LR_INIT(4'b0100), .LR_MIN(4'b0001), .DECAY_EPOCHS(DECAY)
    ) dut (
        .iCLK(iCLK), .iRST(iRST), .iStart(iStart),
        .iNumTrain(iNumTrain), .iNumTest(iNumTest), .iNumEpoch(iNumEpoch),
        .oMode(oMode), .oLR(oLR),
        .oValid_Sample(oValid_Sample), .iReady_Sample(iReady_Sample), .oData_Sample(oData_Sample),
        .iValid_Done(iValid_Done), .oReady_Done(oReady_Done),
        .oEpoch(oEpoch), .oBusy(oBusy), .oDone(oDone)
    );

    always #5 iCLK = ~iCLK;

    typedef struct {
        int mode;
        int idx;
        int ep;
    } tok_t;

    tok_t q[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   pending = 0;
    int   n_xfer = 0;
    int   prev_mode = M_TEST;
    bit   prev_hold = 1'b0;
    int   prev_idx = 0;
    int   job_epochs = 0;

    task automatic chk(input string tag, input int obs, input int expv);
        n_chk++;
        if (obs == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, expv, $time);
    endtask

    function automatic int exp_lr(input int e);
`ifdef SCHED_LR_DECAY_EN
        int v;
        v = LRI >> (e / DECAY);
        return (v < LRM) ? LRM : v;
`else
        return LRI + 0 * e;
`endif
    endfunction

    // Checks the outputs visible this cycle and advances the model by what the next edge transfers.
    task automatic monitor();
        bit   xfer;
        bit   comp;
        tok_t t;
        xfer = oValid_Sample && iReady_Sample;
        comp = iValid_Done && oReady_Done;
        chk("ready_done", int'(oReady_Done), int'(pending > 0));
        if (oValid_Sample) chk("inflight_cap", int'(pending < MAXI), 1);
        if (prev_hold) begin
            chk("hold_valid", int'(oValid_Sample), 1);
            chk("hold_idx", int'(oData_Sample), prev_idx);
        end
        if (int'(oMode) != prev_mode) chk("mode_flip_inflight", pending, 0);
        if (xfer) begin
            if (q.size() == 0) begin
                chk("extra_token", 1, 0);
            end else begin
                t = q.pop_front();
                chk("tok_idx", int'(oData_Sample), t.idx);
                chk("tok_mode", int'(oMode), t.mode);
                chk("tok_lr", int'(oLR), exp_lr(t.ep));
                chk("tok_epoch", int'(oEpoch), t.ep);
            end
            n_xfer++;
        end
        pending   = pending + int'(xfer) - int'(comp);
        prev_hold = oValid_Sample && !iReady_Sample;
        prev_idx  = int'(oData_Sample);
        prev_mode = int'(oMode);
    endtask

    task automatic cycle(input bit r, input bit vd);
        @(negedge iCLK);
        iReady_Sample = r;
        iValid_Done   = vd;
        monitor();
        @(posedge iCLK);
        #1;
    endtask

    task automatic start_job(input int t, input int s, input int e);
        tok_t k;
        q.delete();
        for (int ep = 0; ep < e; ep++) begin
            for (int i = 0; i < t; i++) begin
                k.mode = M_TRAIN; k.idx = i; k.ep = ep; q.push_back(k);
            end
            for (int i = 0; i < s; i++) begin
                k.mode = M_TEST; k.idx = i; k.ep = ep; q.push_back(k);
            end
        end
        job_epochs = e;
        iNumTrain = CW'(t);
        iNumTest  = CW'(s);
        iNumEpoch = CW'(e);
        iStart    = 1'b1;
        cycle(1'b0, 1'b0);
        iStart = 1'b0;
        if (e == 0) begin
            chk("ep0_done", int'(oDone), 1);
            chk("ep0_busy", int'(oBusy), 0);
            chk("ep0_valid", int'(oValid_Sample), 0);
        end else begin
            chk("start_busy", int'(oBusy), 1);
            chk("start_done_clr", int'(oDone), 0);
            chk("start_latency", int'(oValid_Sample), int'(t > 0));
        end
    endtask

    task automatic finish_job(input int rp, input int dp, input int budget);
        int n;
        bit r;
        bit vd;
        n = 0;
        while (!oDone && n < budget) begin
            r  = ($urandom_range(99) < rp);
            vd = (pending > 0) ? ($urandom_range(99) < dp) : ($urandom_range(7) == 0);
            cycle(r, vd);
            n++;
        end
        if (!oDone) chk("timeout", 0, 1);
        chk("end_queue", q.size(), 0);
        chk("end_inflight", pending, 0);
        chk("end_epoch", int'(oEpoch), job_epochs);
        chk("end_mode", int'(oMode), M_TEST);
        chk("end_lr", int'(oLR), exp_lr(job_epochs));
        chk("end_busy", int'(oBusy), 0);
        chk("end_valid", int'(oValid_Sample), 0);
        // DONE is sticky: a few idle cycles must not disturb it.
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b0);
        chk("done_sticky", int'(oDone), 1);
    endtask

    initial begin
        int base;
        repeat (2) @(posedge iCLK);
        #1;
        iRST = 1'b0;
        chk("rst_mode", int'(oMode), M_TEST);
        chk("rst_lr", int'(oLR), LRI);
        chk("rst_valid", int'(oValid_Sample), 0);
        chk("rst_data", int'(oData_Sample), 0);
        chk("rst_ready", int'(oReady_Done), 0);
        chk("rst_epoch", int'(oEpoch), 0);
        chk("rst_busy", int'(oBusy), 0);
        chk("rst_done", int'(oDone), 0);

        // Spurious completions while idle.
        cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b1);
        chk("idle_ready", int'(oReady_Done), 0);
        chk("idle_valid", int'(oValid_Sample), 0);

        // Basic run: 3 train, 2 test, 1 epoch.
        start_job(3, 2, 1);
        finish_job(100, 50, 500);

        // Issue cap with completions held off, then one release.
        start_job(8, 1, 1);
        base = n_xfer;
        repeat (8) cycle(1'b1, 1'b0);
        chk("cap_count", n_xfer - base, MAXI);
        chk("cap_valid", int'(oValid_Sample), 0);
        cycle(1'b1, 1'b1);
        chk("release_valid", int'(oValid_Sample), 1);
        chk("release_idx", int'(oData_Sample), MAXI);
        finish_job(80, 60, 1000);

        // Issue and completion together every cycle: no gaps.
        start_job(6, 2, 1);
        base = n_xfer;
        repeat (6) cycle(1'b1, 1'b1);
        chk("nogap_count", n_xfer - base, 6);
        chk("nogap_inflight", pending, 1);
        finish_job(100, 100, 500);

        // Learning-rate schedule over six epochs.
        start_job(1, 1, 6);
        finish_job(70, 70, 1000);

        // Boundaries.
        start_job(3, 3, 0);
        finish_job(100, 100, 10);
        start_job(0, 2, 1);
        finish_job(90, 60, 500);

        // Reset mid-TRAIN with three in flight.
        start_job(8, 2, 2);
        repeat (3) cycle(1'b1, 1'b0);
        chk("pre_rst_inflight", pending, 3);
        iRST = 1'b1;
        cycle(1'b0, 1'b0);
        chk("mrst_busy", int'(oBusy), 0);
        chk("mrst_mode", int'(oMode), M_TEST);
        chk("mrst_valid", int'(oValid_Sample), 0);
        chk("mrst_lr", int'(oLR), LRI);
        chk("mrst_ready", int'(oReady_Done), 0);
        chk("mrst_epoch", int'(oEpoch), 0);
        iRST = 1'b0;
        q.delete();
        pending   = 0;
        prev_hold = 1'b0;
        prev_mode = int'(oMode);
        start_job(2, 1, 1);
        chk("restart_idx", int'(oData_Sample), 0);
        finish_job(100, 50, 500);

        // Randomized jobs.
        for (int j = 0; j < 8; j++) begin
            start_job(int'($urandom_range(6)), int'($urandom_range(5)), int'($urandom_range(4)));
            finish_job(int'($urandom_range(90, 30)), int'($urandom_range(90, 30)), 3000);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
        $fatal(1);
    end

endmodule

`default_nettype wire
